nist_health_monitor: RTL



---
 rtl/nist_health_monitor.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/nist_health_monitor.sv
// NIST health monitor: edge-detects per-test error levels, keeps sticky flags and
// saturating failure counters, and raises an entropy alarm on too many failures per window.

module nist_hm_lane #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             err_in,
   input  logic             cnt_en,
   input  logic             stk_clr,
   output logic             evt,
   output logic             sticky,
   output logic [CNT_W-1:0] cnt
);
   logic             err_q, err_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign err_d  = err_in;
   assign evt    = err_in & ~err_q;
   assign sticky = sticky_q;
   assign cnt    = cnt_q;

   always_comb begin
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (clr) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end else begin
         if (stk_clr) sticky_d = 1'b0;
         // a new failure in the acknowledge cycle must stay visible
         if (cnt_en && evt) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         err_q    <= err_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

module nist_health_monitor #(
   parameter int N_TESTS       = 3,
   parameter int CNT_W         = 8,
   parameter int WARMUP_CYCLES = 128,
   parameter int WINDOW        = 1024,
   parameter int ALARM_THR     = 4,
   localparam int SEL_W        = (N_TESTS > 1) ? $clog2(N_TESTS) : 1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               clr,
   input  logic [N_TESTS-1:0] err_in,
   input  logic               ack,
   input  logic [SEL_W-1:0]   sel,
   output logic               healthy,
   output logic               alarm,
   output logic [N_TESTS-1:0] sticky,
   output logic [CNT_W-1:0]   fail_cnt
);
   localparam int WARM_W = $clog2(WARMUP_CYCLES);
   localparam int WIN_W  = $clog2(WINDOW);
   localparam int EVT_W  = (ALARM_THR > 1) ? $clog2(ALARM_THR + 1) : 1;
   localparam int PC_W   = $clog2(N_TESTS + 1);
   localparam int SUM_W  = ((EVT_W > PC_W) ? EVT_W : PC_W) + 1;

   typedef enum logic [1:0] {ST_WARMUP, ST_MONITOR, ST_ALARM} state_t;

   state_t                          state_q, state_d;
   logic   [WARM_W-1:0]             warm_cnt_q, warm_cnt_d;
   logic   [WIN_W-1:0]              win_cnt_q, win_cnt_d;
   logic   [EVT_W-1:0]              win_evt_q, win_evt_d;
   logic   [N_TESTS-1:0]            evt;
   logic   [N_TESTS-1:0][CNT_W-1:0] cnt;
   logic   [PC_W-1:0]               pop;
   logic   [SUM_W-1:0]              win_sum;
   logic                            wrap, cnt_en, stk_clr;

   assign cnt_en  = (state_q != ST_WARMUP);
   assign stk_clr = (state_q == ST_ALARM) && ack;
   assign healthy = (state_q == ST_MONITOR);
   assign alarm   = (state_q == ST_ALARM);

   for (genvar g = 0; g < N_TESTS; g++) begin : g_lane
      nist_hm_lane #(.CNT_W(CNT_W)) u_lane (
         .clk     (clk),
         .rstn    (rstn),
         .clr     (clr),
         .err_in  (err_in[g]),
         .cnt_en  (cnt_en),
         .stk_clr (stk_clr),
         .evt     (evt[g]),
         .sticky  (sticky[g]),
         .cnt     (cnt[g])
      );
   end

   always_comb begin
      fail_cnt = '0;
      for (int i = 0; i < N_TESTS; i++)
         if (sel == SEL_W'(i)) fail_cnt = cnt[i];
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < N_TESTS; i++) pop = pop + PC_W'(evt[i]);
   end

   // the wrap cycle's events open the next window instead of closing the old one
   assign wrap    = (win_cnt_q == WIN_W'(WINDOW - 1));
   assign win_sum = (wrap ? '0 : SUM_W'(win_evt_q)) + SUM_W'(pop);

   always_comb begin
      state_d    = state_q;
      warm_cnt_d = warm_cnt_q;
      win_cnt_d  = win_cnt_q;
      win_evt_d  = win_evt_q;
      if (clr) begin
         state_d    = ST_WARMUP;
         warm_cnt_d = '0;
         win_cnt_d  = '0;
         win_evt_d  = '0;
      end else begin
         case (state_q)
            ST_WARMUP: begin
               if (warm_cnt_q == WARM_W'(WARMUP_CYCLES - 1)) begin
                  state_d    = ST_MONITOR;
                  warm_cnt_d = '0;
               end else begin
                  warm_cnt_d = warm_cnt_q + 1'b1;
               end
            end
            ST_MONITOR: begin
               win_cnt_d = wrap ? '0 : win_cnt_q + 1'b1;
               if (win_sum >= SUM_W'(ALARM_THR)) begin
                  win_evt_d = EVT_W'(ALARM_THR);
                  state_d   = ST_ALARM;
               end else begin
                  win_evt_d = EVT_W'(win_sum);
               end
            end
            ST_ALARM: begin
               if (ack) begin
                  state_d   = ST_MONITOR;
                  win_cnt_d = '0;
                  win_evt_d = '0;
               end
            end
            default: state_d = ST_WARMUP;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_WARMUP;
         warm_cnt_q <= '0;
         win_cnt_q  <= '0;
         win_evt_q  <= '0;
      end else begin
         state_q    <= state_d;
         warm_cnt_q <= warm_cnt_d;
         win_cnt_q  <= win_cnt_d;
         win_evt_q  <= win_evt_d;
      end
   end
endmodule
